// File: rtl/key_debounce_sevenseg_if.sv
// Front-panel bus: raw/debounced push-buttons and 7-segment digit/segment lines.
// The master side drives pins and digits; the slave side is the debounce/decode block.
interface key_debounce_sevenseg_if #(
  parameter int unsigned NKEYS = 3,
  parameter int unsigned NDIG  = 6
);
  logic [NKEYS-1:0]  key_n;
  logic [NKEYS-1:0]  key_level;
  logic [NKEYS-1:0]  key_pulse;
  logic [4*NDIG-1:0] digit;
  logic [7*NDIG-1:0] hex;

  modport master (output key_n, digit, input key_level, key_pulse, hex);
  modport slave  (input key_n, digit, output key_level, key_pulse, hex);
endinterface

// File: rtl/key_debounce_sevenseg.sv
// Stopwatch front panel: per-key 2-flop sync + counter debounce with a press pulse,
// plus a combinational hex-to-7-segment (active-low) decoder for every display.
module key_debounce_sevenseg #(
  parameter int unsigned NKEYS           = 3,
  parameter int unsigned NDIG            = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input logic                    CLOCK_50,
  input logic                    reset_,
  key_debounce_sevenseg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] s1;
  logic [NKEYS-1:0] s2;
  logic [NKEYS-1:0] level;
  logic [NKEYS-1:0] pulse;
  logic [CNT_W-1:0] cnt [NKEYS];

  // Counter runs only while the synced pin disagrees with the debounced level,
  // so it always clears before it could pass CNT_LAST.
  always_ff @(posedge CLOCK_50 or negedge reset_) begin
    if (!reset_) begin
      s1    <= '0;
      s2    <= '0;
      level <= '0;
      pulse <= '0;
      for (int k = 0; k < NKEYS; k++) cnt[k] <= '0;
    end else begin
      s1 <= ~bus.key_n;
      s2 <= s1;
      for (int k = 0; k < NKEYS; k++) begin
        pulse[k] <= 1'b0;
        if (s2[k] == level[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_LAST) begin
          level[k] <= s2[k];
          pulse[k] <= s2[k];
          cnt[k]   <= '0;
        end else begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.key_level = level;
  assign bus.key_pulse = pulse;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h7F;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign bus.hex[7*i +: 7] = seg7(bus.digit[4*i +: 4]);
  end

endmodule

// File: tb/tb_key_debounce_sevenseg.sv
// Directed bench for key_debounce_sevenseg with DEBOUNCE_CYCLES=4: press latency,
// bounce/glitch rejection, release/re-press, multi-key, mid-count reset, decoder table.
module tb_key_debounce_sevenseg;

  localparam int unsigned NKEYS = 3;
  localparam int unsigned NDIG  = 6;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic CLOCK_50 = 1'b0;
  logic reset_;
  int   checks = 0;
  int   errors = 0;
  int   pcount [NKEYS];

  always #5 CLOCK_50 = ~CLOCK_50;

  key_debounce_sevenseg_if #(.NKEYS(NKEYS), .NDIG(NDIG)) bus ();

  key_debounce_sevenseg #(
    .NKEYS(NKEYS), .NDIG(NDIG), .DEBOUNCE_CYCLES(4), .CNT_W(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset_  (reset_),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge, tally any pulses seen.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
    for (int k = 0; k < NKEYS; k++) pcount[k] += int'(bus.key_pulse[k]);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NKEYS; k++) pcount[k] = 0;
  endtask

  initial begin
    logic [4*NDIG-1:0] dg;
    clear_counts();
    reset_    = 1'b0;
    bus.key_n = '0;
    bus.digit = '0;

    // Reset with all keys held
    repeat (3) step();
    check("rst_level", 64'(bus.key_level), 64'(0));
    check("rst_pulse", 64'(bus.key_pulse), 64'(0));

    // Release reset with keys still held: single press after 2+4 cycles
    reset_ = 1'b1;
    clear_counts();
    repeat (5) step();
    check("t1_level_early", 64'(bus.key_level), 64'(0));
    step();
    check("t1_level", 64'(bus.key_level), 64'(3'b111));
    check("t1_pulse", 64'(bus.key_pulse), 64'(3'b111));
    step();
    check("t1_pulse_off", 64'(bus.key_pulse), 64'(0));
    repeat (5) step();
    check("t1_pulse_cnt", 64'(pcount[0] + pcount[1] + pcount[2]), 64'(3));

    bus.key_n = '1;
    clear_counts();
    repeat (10) step();
    check("t1_release_level", 64'(bus.key_level), 64'(0));
    check("t1_release_nopulse", 64'(pcount[0] + pcount[1] + pcount[2]), 64'(0));

    // Clean press on key 0, held 20 cycles
    bus.key_n[0] = 1'b0;
    clear_counts();
    repeat (5) step();
    check("t2_pulse_early", 64'(bus.key_pulse), 64'(0));
    step();
    check("t2_pulse", 64'(bus.key_pulse), 64'(3'b001));
    check("t2_level", 64'(bus.key_level), 64'(3'b001));
    repeat (14) step();
    check("t2_pulse_cnt", 64'(pcount[0]), 64'(1));
    check("t2_level_held", 64'(bus.key_level), 64'(3'b001));

    // Release 10 cycles, then re-press
    bus.key_n[0] = 1'b1;
    clear_counts();
    repeat (10) step();
    check("t4_release_level", 64'(bus.key_level), 64'(0));
    check("t4_release_nopulse", 64'(pcount[0]), 64'(0));
    bus.key_n[0] = 1'b0;
    clear_counts();
    repeat (6) step();
    check("t4_repress_pulse", 64'(bus.key_pulse), 64'(3'b001));
    repeat (4) step();
    check("t4_repress_cnt", 64'(pcount[0]), 64'(1));
    bus.key_n[0] = 1'b1;
    repeat (10) step();

    // Bounce on key 1: toggle every 2 cycles for 16 cycles, then settle pressed
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      bus.key_n[1] = ~bus.key_n[1];
      repeat (2) step();
    end
    check("t3_bounce_nopulse", 64'(pcount[1]), 64'(0));
    check("t3_bounce_level", 64'(bus.key_level), 64'(0));
    bus.key_n[1] = 1'b0;
    repeat (5) step();
    check("t3_settle_early", 64'(bus.key_pulse), 64'(0));
    step();
    check("t3_settle_pulse", 64'(bus.key_pulse), 64'(3'b010));
    repeat (4) step();
    check("t3_settle_cnt", 64'(pcount[1]), 64'(1));

    // 3-cycle glitch alone
    bus.key_n[1] = 1'b1;
    repeat (10) step();
    clear_counts();
    check("t3_pre_glitch_level", 64'(bus.key_level), 64'(0));
    bus.key_n[1] = 1'b0;
    repeat (3) step();
    bus.key_n[1] = 1'b1;
    repeat (10) step();
    check("t3_glitch_nopulse", 64'(pcount[1]), 64'(0));
    check("t3_glitch_level", 64'(bus.key_level), 64'(0));

    // Two keys pressed in the same cycle
    clear_counts();
    bus.key_n = 3'b100;
    repeat (6) step();
    check("t5_dual_pulse", 64'(bus.key_pulse), 64'(3'b011));
    step();
    check("t5_dual_off", 64'(bus.key_pulse), 64'(0));
    bus.key_n = '1;
    repeat (10) step();
    check("t5_dual_cnt0", 64'(pcount[0]), 64'(1));
    check("t5_dual_cnt1", 64'(pcount[1]), 64'(1));

    // Reset asserted mid-count
    clear_counts();
    bus.key_n[2] = 1'b0;
    repeat (3) step();
    reset_    = 1'b0;
    bus.key_n = '1;
    repeat (2) step();
    check("t5_rst_level", 64'(bus.key_level), 64'(0));
    check("t5_rst_pulse", 64'(bus.key_pulse), 64'(0));
    reset_ = 1'b1;
    repeat (10) step();
    check("t5_rst_nopulse", 64'(pcount[2]), 64'(0));
    check("t5_rst_level_after", 64'(bus.key_level), 64'(0));

    // Decoder sweep, same code on all digits (decoder also checked under reset)
    reset_ = 1'b0;
    for (int v = 0; v < 16; v++) begin
      bus.digit = {NDIG{4'(v)}};
      #1;
      check($sformatf("t6_dec_%0h", v), 64'(bus.hex), 64'({NDIG{SEG[v]}}));
    end
    reset_ = 1'b1;
    dg = 24'hF90A5C;
    bus.digit = dg;
    #1;
    check("t6_dec_mixed", 64'(bus.hex),
          64'({7'h0E, 7'h10, 7'h40, 7'h08, 7'h12, 7'h46}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
